reg_access_ctrl: RTL and testbench

Initiator-side sequencer for the single-port 16x32 register file. It accepts one instruction's register operands (rs1, rs2, rd), issues two sequential read commands and captures both operands. It presents the operands to the ALU through a valid/ready handshake, then issues the write-back command for the ALU result. It also owns the register-file clear command and counts retired instructions.

---
 rtl/reg_access_ctrl_pkg.sv | 25 ++
 rtl/reg_access_ctrl.sv | 157 +++++++++++++++
 tb/tb_reg_access_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_access_ctrl_pkg.sv
// Shared definitions for the register-file access sequencer: state encoding,
// default widths and register-file geometry.
package reg_access_ctrl_pkg;

    localparam int RF_DEPTH   = 16;
    localparam int ADDR_W_DEF = $clog2(RF_DEPTH);
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W_DEF  = 16;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CLEAR    = 3'd1,
        ST_RD_A     = 3'd2,
        ST_RD_B     = 3'd3,
        ST_CAP_B    = 3'd4,
        ST_EXEC     = 3'd5,
        ST_WAIT_RES = 3'd6,
        ST_WRITE    = 3'd7
    } state_t;

    function automatic logic is_busy(input state_t st);
        return (st != ST_IDLE);
    endfunction

endpackage

// File: rtl/reg_access_ctrl.sv
// Initiator-side sequencer for the single-port register file: two operand
// reads, ALU handshake, optional write-back, clear command, retire counter.
module reg_access_ctrl
    import reg_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_rs1,
    input  logic [ADDR_W-1:0] req_rs2,
    input  logic [ADDR_W-1:0] req_rd,
    input  logic              req_wb,
    input  logic              clear_req,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [DATA_W-1:0] res_data,
    output logic [ADDR_W-1:0] rf_address,
    output logic [DATA_W-1:0] rf_value,
    output logic              rf_write,
    output logic              rf_read,
    output logic              rf_reset,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic              busy,
    output logic [CNT_W-1:0]  instr_count
);

    state_t              state_r;
    logic [ADDR_W-1:0]   rs2_r;
    logic [ADDR_W-1:0]   rd_r;
    logic                wb_r;
    logic [ADDR_W-1:0]   rf_address_r;
    logic [DATA_W-1:0]   rf_value_r;
    logic                rf_write_r;
    logic                rf_read_r;
    logic                rf_reset_r;
    logic                op_valid_r;
    logic [DATA_W-1:0]   op_a_r;
    logic [DATA_W-1:0]   op_b_r;
    logic [CNT_W-1:0]    instr_count_r;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    assign req_ready   = (state_r == ST_IDLE) && !clear_req;
    assign res_ready   = (state_r == ST_WAIT_RES);
    assign busy        = is_busy(state_r);
    assign rf_address  = rf_address_r;
    assign rf_value    = rf_value_r;
    assign rf_write    = rf_write_r;
    assign rf_read     = rf_read_r;
    assign rf_reset    = rf_reset_r;
    assign op_valid    = op_valid_r;
    assign op_a        = op_a_r;
    assign op_b        = op_b_r;
    assign instr_count = instr_count_r;

    // Sequencer FSM with all register-file strobes and operands registered.
    // rf_read stays high across RD_A/RD_B so both operands are fetched even
    // when rs1 == rs2; the regfile answers one cycle after each strobe edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r       <= ST_IDLE;
            rs2_r         <= {ADDR_W{1'b0}};
            rd_r          <= {ADDR_W{1'b0}};
            wb_r          <= 1'b0;
            rf_address_r  <= {ADDR_W{1'b0}};
            rf_value_r    <= {DATA_W{1'b0}};
            rf_write_r    <= 1'b0;
            rf_read_r     <= 1'b0;
            rf_reset_r    <= 1'b0;
            op_valid_r    <= 1'b0;
            op_a_r        <= {DATA_W{1'b0}};
            op_b_r        <= {DATA_W{1'b0}};
            instr_count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (clear_req) begin
                        rf_reset_r <= 1'b1;
                        state_r    <= ST_CLEAR;
                    end else if (req_valid) begin
                        rs2_r        <= req_rs2;
                        rd_r         <= req_rd;
                        wb_r         <= req_wb;
                        rf_address_r <= req_rs1;
                        rf_read_r    <= 1'b1;
                        state_r      <= ST_RD_A;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_CLEAR: begin
                    rf_reset_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
                ST_RD_A: begin
                    rf_address_r <= rs2_r;
                    state_r      <= ST_RD_B;
                end
                ST_RD_B: begin
                    op_a_r    <= rf_data_out;
                    rf_read_r <= 1'b0;
                    state_r   <= ST_CAP_B;
                end
                ST_CAP_B: begin
                    op_b_r     <= rf_data_out;
                    op_valid_r <= 1'b1;
                    state_r    <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (op_ready) begin
                        op_valid_r <= 1'b0;
                        if (wb_r) begin
                            state_r <= ST_WAIT_RES;
                        end else begin
                            instr_count_r <= instr_count_r + CNT_ONE;
                            state_r       <= ST_IDLE;
                        end
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_WAIT_RES: begin
                    if (res_valid) begin
                        rf_address_r <= rd_r;
                        rf_value_r   <= res_data;
                        rf_write_r   <= 1'b1;
                        state_r      <= ST_WRITE;
                    end else begin
                        state_r <= ST_WAIT_RES;
                    end
                end
                ST_WRITE: begin
                    rf_write_r    <= 1'b0;
                    instr_count_r <= instr_count_r + CNT_ONE;
                    state_r       <= ST_IDLE;
                end
                default: begin
                    rf_write_r <= 1'b0;
                    rf_read_r  <= 1'b0;
                    rf_reset_r <= 1'b0;
                    op_valid_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Self-checking bench: behavioural register file as responder plus a
// per-instruction reference model of register contents and retire count.
module tb_reg_access_ctrl;
    import reg_access_ctrl_pkg::*;

    localparam int TB_CNT_W = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_wb, clear_req;
    logic [3:0]  req_rs1, req_rs2, req_rd;
    logic        op_valid, op_ready, res_valid, res_ready;
    logic [31:0] op_a, op_b, res_data;
    logic [3:0]  rf_address;
    logic [31:0] rf_value, rf_data_out;
    logic        rf_write, rf_read, rf_reset, busy;
    logic [TB_CNT_W-1:0] instr_count;

    logic [31:0] rf_mem [RF_DEPTH];
    logic [31:0] ref_mem [RF_DEPTH];
    logic        pre_we;
    logic [3:0]  pre_addr;
    logic [31:0] pre_data;
    int mon_rd = 0, mon_wr = 0, mon_rst = 0, mon_excl = 0;
    int checks = 0, errors = 0;
    int ref_count = 0;

    reg_access_ctrl #(.ADDR_W(4), .DATA_W(32), .CNT_W(TB_CNT_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd), .req_wb(req_wb),
        .clear_req(clear_req),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .rf_address(rf_address), .rf_value(rf_value), .rf_write(rf_write),
        .rf_read(rf_read), .rf_reset(rf_reset), .rf_data_out(rf_data_out),
        .busy(busy), .instr_count(instr_count)
    );

    always #5 clock = ~clock;

    // Register file responder; pre_we is a bench-only preload port.
    always @(posedge clock) begin
        if (pre_we) rf_mem[pre_addr] <= pre_data;
        else if (rf_reset) for (int i = 0; i < RF_DEPTH; i++) rf_mem[i] <= 32'd0;
        else if (rf_write) rf_mem[rf_address] <= rf_value;
        if (rf_read) rf_data_out <= rf_mem[rf_address];
    end

    // Strobe monitor.
    always @(negedge clock) begin
        if (rf_read === 1'b1)  mon_rd  <= mon_rd + 1;
        if (rf_write === 1'b1) mon_wr  <= mon_wr + 1;
        if (rf_reset === 1'b1) mon_rst <= mon_rst + 1;
        if ((32'(rf_read === 1'b1) + 32'(rf_write === 1'b1) + 32'(rf_reset === 1'b1)) > 32'd1)
            mon_excl <= mon_excl + 1;
    end

    task automatic preload(input logic [3:0] a, input logic [31:0] d);
        @(negedge clock);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clock);
        pre_we = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic do_instr(input logic [3:0] rs1, input logic [3:0] rs2, input logic [3:0] rd,
                            input logic wb, input logic [31:0] res, input int op_hold, input int res_delay,
                            output logic [31:0] got_a, output logic [31:0] got_b, output int lat,
                            output logic stable, output logic early_wr, output logic timed_out);
        int n;
        int wr0;
        stable = 1'b1; early_wr = 1'b0; timed_out = 1'b0; lat = 0; got_a = 32'd0; got_b = 32'd0;
        n = 0;
        while (!req_ready && n < 50) begin @(negedge clock); n++; end
        if (!req_ready) begin timed_out = 1'b1; return; end
        req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2; req_rd = rd; req_wb = wb;
        @(negedge clock);
        req_valid = 1'b0;
        lat = 1;
        while (op_valid !== 1'b1 && lat < 20) begin @(negedge clock); lat++; end
        if (op_valid !== 1'b1) begin timed_out = 1'b1; return; end
        got_a = op_a; got_b = op_b;
        for (int i = 0; i < op_hold; i++) begin
            @(negedge clock);
            if (op_valid !== 1'b1 || op_a !== got_a || op_b !== got_b) stable = 1'b0;
        end
        op_ready = 1'b1;
        @(negedge clock);
        op_ready = 1'b0;
        if (op_valid !== 1'b0) stable = 1'b0;
        if (wb) begin
            wr0 = mon_wr;
            res_data = res;
            for (int i = 0; i < res_delay; i++) begin
                @(negedge clock);
                if (rf_write !== 1'b0) early_wr = 1'b1;
            end
            if (mon_wr != wr0) early_wr = 1'b1;
            res_valid = 1'b1;
            @(negedge clock);
            res_valid = 1'b0;
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({rf_address, rf_value, rf_write, rf_read, rf_reset, op_valid, op_a, op_b, instr_count, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: addr=%h val=%h wr=%b rd=%b rst=%b ov=%b a=%h b=%h cnt=%h busy=%b, required all zero",
                     rf_address, rf_value, rf_write, rf_read, rf_reset, op_valid, op_a, op_b, instr_count, busy);
        end
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b required 1", req_ready); end
        for (int i = 0; i < RF_DEPTH; i++) preload(4'(i), $urandom);
    endtask

    task automatic test_basic();
        logic [31:0] a, b; int lat; logic st, ew, to; int rd0, wr0;
        preload(4'd3, 32'h0000_0011);
        preload(4'd5, 32'h0000_0022);
        rd0 = mon_rd; wr0 = mon_wr;
        do_instr(4'd3, 4'd5, 4'd7, 1'b1, 32'h0000_0033, 0, 0, a, b, lat, st, ew, to);
        ref_mem[7] = 32'h0000_0033; ref_count++;
        @(negedge clock);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: handshake did not complete"); end
        checks++; if (lat != 4) begin errors++; $display("FAIL basic_latency: got %0d required 4", lat); end
        checks++; if (a !== 32'h11 || b !== 32'h22) begin errors++; $display("FAIL basic_operands: got %h/%h required 11/22", a, b); end
        checks++; if (rf_mem[7] !== 32'h33) begin errors++; $display("FAIL basic_writeback: Reg[7]=%h required 33", rf_mem[7]); end
        checks++; if (instr_count !== 8'd1) begin errors++; $display("FAIL basic_count: got %0d required 1", instr_count); end
        checks++; if (mon_rd - rd0 != 2 || mon_wr - wr0 != 1) begin
            errors++; $display("FAIL basic_strobes: reads %0d writes %0d required 2 and 1", mon_rd - rd0, mon_wr - wr0); end
    endtask

    task automatic test_same_src_no_wb();
        logic [31:0] a, b; int lat; logic st, ew, to; int rd0, wr0;
        preload(4'd9, 32'hDEAD_BEEF);
        rd0 = mon_rd; wr0 = mon_wr;
        do_instr(4'd9, 4'd9, 4'd2, 1'b0, 32'h1234_5678, 0, 0, a, b, lat, st, ew, to);
        ref_count++;
        @(negedge clock);
        checks++; if (to || a !== 32'hDEAD_BEEF || b !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL same_src_operands: got %h/%h required deadbeef/deadbeef", a, b); end
        checks++; if (mon_rd - rd0 != 2) begin errors++; $display("FAIL same_src_reads: got %0d required 2", mon_rd - rd0); end
        checks++; if (mon_wr != wr0 || rf_mem[2] !== ref_mem[2]) begin
            errors++; $display("FAIL nowb_no_write: writes %0d Reg[2]=%h required 0 and %h", mon_wr - wr0, rf_mem[2], ref_mem[2]); end
        checks++; if (busy !== 1'b0 || instr_count !== 8'(ref_count)) begin
            errors++; $display("FAIL nowb_retire: busy=%b cnt=%0d required 0 and %0d", busy, instr_count, ref_count); end
    endtask

    task automatic test_clear();
        logic [31:0] a, b; int lat; logic st, ew, to; int rst0, rd0;
        rst0 = mon_rst; rd0 = mon_rd;
        @(negedge clock);
        clear_req = 1'b1; req_valid = 1'b1; req_rs1 = 4'd1; req_rs2 = 4'd1; req_rd = 4'd1; req_wb = 1'b1;
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL clear_req_ready: got %b required 0", req_ready); end
        @(negedge clock);
        clear_req = 1'b0; req_valid = 1'b0;
        checks++; if (rf_reset !== 1'b1 || rf_read !== 1'b0) begin
            errors++; $display("FAIL clear_pulse: rst=%b rd=%b required 1 and 0", rf_reset, rf_read); end
        @(negedge clock);
        checks++; if (rf_reset !== 1'b0 || busy !== 1'b0 || mon_rst - rst0 != 1 || mon_rd != rd0) begin
            errors++; $display("FAIL clear_one_cycle: rst=%b busy=%b pulses=%0d reads=%0d required 0,0,1,0",
                               rf_reset, busy, mon_rst - rst0, mon_rd - rd0); end
        for (int i = 0; i < RF_DEPTH; i++) ref_mem[i] = 32'd0;
        do_instr(4'd7, 4'd3, 4'd0, 1'b0, 32'd0, 0, 0, a, b, lat, st, ew, to);
        ref_count++;
        checks++; if (to || a !== ref_mem[7] || b !== ref_mem[3]) begin
            errors++; $display("FAIL clear_readback: got %h/%h required 0/0", a, b); end
    endtask

    task automatic test_stall();
        logic [31:0] a, b; int lat; logic st, ew, to;
        preload(4'd12, 32'hCAFE_0001);
        preload(4'd13, 32'h0BAD_F00D);
        do_instr(4'd12, 4'd13, 4'd14, 1'b1, 32'h5A5A_A5A5, 5, 3, a, b, lat, st, ew, to);
        ref_mem[14] = 32'h5A5A_A5A5; ref_count++;
        checks++; if (to || !st) begin errors++; $display("FAIL stall_stable: stable=%b timeout=%b required 1 and 0", st, to); end
        checks++; if (ew) begin errors++; $display("FAIL stall_early_write: got early write required none"); end
        checks++; if (a !== 32'hCAFE_0001 || b !== 32'h0BAD_F00D || rf_mem[14] !== 32'h5A5A_A5A5) begin
            errors++; $display("FAIL stall_data: a=%h b=%h Reg[14]=%h required cafe0001 0badf00d 5a5aa5a5", a, b, rf_mem[14]); end
    endtask

    task automatic test_random();
        logic [31:0] a, b, r; int lat; logic st, ew, to; int rd0, wr0, nwb;
        logic [3:0] s1, s2, d; logic w;
        int bad;
        rd0 = mon_rd; wr0 = mon_wr; nwb = 0;
        for (int k = 0; k < 25; k++) begin
            s1 = 4'($urandom_range(0, 15)); s2 = 4'($urandom_range(0, 15));
            d = 4'($urandom_range(0, 15)); w = 1'($urandom_range(0, 1)); r = $urandom;
            do_instr(s1, s2, d, w, r, $urandom_range(0, 3), $urandom_range(0, 3), a, b, lat, st, ew, to);
            checks++;
            if (to || lat != 4 || !st || ew || a !== ref_mem[s1] || b !== ref_mem[s2]) begin
                errors++;
                $display("FAIL rand_instr%0d: a=%h b=%h lat=%0d st=%b ew=%b to=%b required a=%h b=%h lat=4 st=1 ew=0 to=0",
                         k, a, b, lat, st, ew, to, ref_mem[s1], ref_mem[s2]);
            end
            if (w) begin ref_mem[d] = r; nwb++; end
            ref_count++;
            checks++;
            if (instr_count !== 8'(ref_count)) begin
                errors++; $display("FAIL rand_count%0d: got %0d required %0d", k, instr_count, 8'(ref_count));
            end
        end
        @(negedge clock);
        bad = 0;
        for (int i = 0; i < RF_DEPTH; i++) if (rf_mem[i] !== ref_mem[i]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL rand_regfile: %0d entries differ, required 0", bad); end
        checks++; if (mon_rd - rd0 != 50 || mon_wr - wr0 != nwb) begin
            errors++; $display("FAIL rand_strobes: reads %0d writes %0d required 50 and %0d", mon_rd - rd0, mon_wr - wr0, nwb); end
    endtask

    task automatic test_abort();
        int n, wr0, rst0;
        preload(4'd1, 32'h1111_1111);
        preload(4'd2, 32'h2222_2222);
        @(negedge clock);
        req_valid = 1'b1; req_rs1 = 4'd1; req_rs2 = 4'd2; req_rd = 4'd4; req_wb = 1'b1;
        @(negedge clock);
        req_valid = 1'b0;
        n = 0;
        while (op_valid !== 1'b1 && n < 20) begin @(negedge clock); n++; end
        op_ready = 1'b1;
        @(negedge clock);
        op_ready = 1'b0;
        checks++; if (res_ready !== 1'b1 || req_ready !== 1'b0) begin
            errors++; $display("FAIL abort_wait_res: res_ready=%b req_ready=%b required 1 and 0", res_ready, req_ready); end
        rst0 = mon_rst; wr0 = mon_wr;
        clear_req = 1'b1;
        @(negedge clock);
        clear_req = 1'b0;
        reset = 1'b0; res_valid = 1'b1; res_data = 32'h5555_5555;
        @(negedge clock);
        reset = 1'b1; res_valid = 1'b0;
        checks++;
        if ({rf_address, rf_value, rf_write, rf_read, rf_reset, op_valid, op_a, op_b, instr_count, busy} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: addr=%h val=%h wr=%b ov=%b a=%h b=%h cnt=%0d busy=%b required all zero",
                     rf_address, rf_value, rf_write, op_valid, op_a, op_b, instr_count, busy);
        end
        ref_count = 0;
        repeat (3) @(negedge clock);
        checks++; if (mon_wr != wr0 || mon_rst != rst0 || rf_mem[4] !== ref_mem[4]) begin
            errors++; $display("FAIL abort_no_write: writes %0d clears %0d Reg[4]=%h required 0, 0, %h",
                               mon_wr - wr0, mon_rst - rst0, rf_mem[4], ref_mem[4]); end
    endtask

    task automatic test_wrap();
        logic [31:0] a, b; int lat; logic st, ew, to; int tos;
        tos = 0;
        for (int k = 0; k < 255; k++) begin
            do_instr(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 4'd0, 1'b0, 32'd0, 0, 0, a, b, lat, st, ew, to);
            if (to) tos++;
            ref_count++;
        end
        checks++; if (tos != 0 || instr_count !== 8'(ref_count)) begin
            errors++; $display("FAIL wrap_max: got %0d (timeouts %0d) required %0d", instr_count, tos, 8'(ref_count)); end
        do_instr(4'd5, 4'd6, 4'd8, 1'b1, 32'h0000_00AB, 0, 0, a, b, lat, st, ew, to);
        ref_mem[8] = 32'h0000_00AB; ref_count++;
        checks++; if (to || instr_count !== 8'(ref_count)) begin
            errors++; $display("FAIL wrap_zero: got %0d required %0d", instr_count, 8'(ref_count)); end
        checks++; if (mon_excl != 0) begin errors++; $display("FAIL strobe_exclusive: %0d overlap cycles required 0", mon_excl); end
    endtask

    initial begin
        reset = 1'b0; req_valid = 1'b0; req_rs1 = 4'd0; req_rs2 = 4'd0; req_rd = 4'd0; req_wb = 1'b0;
        clear_req = 1'b0; op_ready = 1'b0; res_valid = 1'b0; res_data = 32'd0;
        pre_we = 1'b0; pre_addr = 4'd0; pre_data = 32'd0;
        test_reset();
        test_basic();
        test_same_src_no_wb();
        test_clear();
        test_stall();
        test_random();
        test_abort();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
